gmii_rx_frame_check: RTL

Receive-side frame checker that consumes the byte-wide GMII stream produced by the RGMII-to-GMII converter. It strips preamble and SFD, validates the Ethernet FCS (CRC-32), enforces length limits, and emits the payload as a byte stream with the FCS removed. It also emits one status word per frame and keeps saturating error counters for the LED and SPI diagnostics path of the hardware test.

---
 rtl/gmii_rx_frame_check_pkg.sv | 23 ++
 rtl/crc32_byte.sv | 20 ++
 rtl/gmii_rx_frame_check.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gmii_rx_frame_check_pkg.sv
// Shared constants, state encoding and helpers for the GMII receive frame checker.
// Imported by the checker top and the CRC-32 byte updater.
package gmii_rx_frame_check_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
   localparam logic [31:0] CRC_POLY_REF  = 32'hEDB8_8320;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_DATA  = 3'd2,
      ST_ABORT = 3'd3,
      ST_DROP  = 3'd4
   } state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 update over one byte, LSB first.
// Shared between the receive checker and the transmit path.
module crc32_byte
   import gmii_rx_frame_check_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  d,
   output logic [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      c = crc_in ^ {24'h0, d};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/gmii_rx_frame_check.sv
// GMII receive frame checker: strips preamble/SFD, checks FCS and length,
// streams the payload without FCS and keeps saturating error counters.
module gmii_rx_frame_check
   import gmii_rx_frame_check_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  gmii_rxd,
   input  logic        gmii_rx_dv,
   input  logic        gmii_rx_er,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        status_valid,
   output logic        status_good,
   output logic [10:0] status_len,
   output logic [15:0] good_count,
   output logic [15:0] crc_err_count,
   output logic [15:0] rx_er_count,
   output logic [15:0] len_err_count,
   output logic [15:0] align_err_count
);

   localparam logic [10:0] MIN_L = 11'(MIN_LEN);
   localparam logic [10:0] MAX_L = 11'(MAX_LEN);

   state_t      state;
   logic        dv_prev;
   logic [31:0] crc;
   logic [31:0] crc_next;
   logic [10:0] len;
   logic [7:0]  dl [4];
   logic [2:0]  fill;
   logic        len_bad;
   logic        crc_ok;
   logic        pre_ok;

   crc32_byte u_crc (
      .crc_in  (crc),
      .d       (gmii_rxd),
      .crc_out (crc_next)
   );

   assign len_bad = (len < MIN_L) || (len > MAX_L);
   assign crc_ok  = (crc == CRC_RESIDUE);
   assign pre_ok  = (gmii_rxd == PREAMBLE_BYTE) || (gmii_rxd == SFD_BYTE);

   // dv_prev resets high so a frame already running at reset is skipped
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         dv_prev         <= 1'b1;
         crc             <= '0;
         len             <= '0;
         dl              <= '{default: 8'h00};
         fill            <= '0;
         out_data        <= '0;
         out_valid       <= 1'b0;
         status_valid    <= 1'b0;
         status_good     <= 1'b0;
         status_len      <= '0;
         good_count      <= '0;
         crc_err_count   <= '0;
         rx_er_count     <= '0;
         len_err_count   <= '0;
         align_err_count <= '0;
      end else begin
         dv_prev      <= gmii_rx_dv;
         out_valid    <= 1'b0;
         status_valid <= 1'b0;
         unique case (state)
            ST_IDLE, ST_PRE: begin
               if (state == ST_PRE && !gmii_rx_dv) begin
                  state           <= ST_IDLE;
                  align_err_count <= sat_inc(align_err_count);
               end else if (gmii_rx_dv &&
                            (state == ST_PRE || !dv_prev)) begin
                  if (gmii_rx_er || !pre_ok) begin
                     state           <= ST_DROP;
                     align_err_count <= sat_inc(align_err_count);
                  end else if (gmii_rxd == SFD_BYTE) begin
                     state <= ST_DATA;
                     crc   <= CRC_INIT;
                     len   <= '0;
                     fill  <= '0;
                  end else begin
                     state <= ST_PRE;
                  end
               end
            end
            ST_DATA: begin
               if (!gmii_rx_dv) begin
                  state        <= ST_IDLE;
                  status_valid <= 1'b1;
                  status_good  <= !len_bad && crc_ok;
                  status_len   <= len;
                  if (len_bad)
                     len_err_count <= sat_inc(len_err_count);
                  else if (!crc_ok)
                     crc_err_count <= sat_inc(crc_err_count);
                  else
                     good_count <= sat_inc(good_count);
               end else if (gmii_rx_er) begin
                  state       <= ST_ABORT;
                  rx_er_count <= sat_inc(rx_er_count);
               end else begin
                  crc <= crc_next;
                  if (len != 11'h7FF)
                     len <= len + 11'd1;
                  // four-byte delay keeps the trailing FCS off the output
                  dl[0] <= gmii_rxd;
                  dl[1] <= dl[0];
                  dl[2] <= dl[1];
                  dl[3] <= dl[2];
                  if (fill == 3'd4) begin
                     out_data  <= dl[3];
                     out_valid <= 1'b1;
                  end else begin
                     fill <= fill + 3'd1;
                  end
               end
            end
            ST_ABORT: begin
               if (!gmii_rx_dv) begin
                  state        <= ST_IDLE;
                  status_valid <= 1'b1;
                  status_good  <= 1'b0;
                  status_len   <= len;
               end
            end
            ST_DROP: begin
               if (!gmii_rx_dv)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
